// File: rtl/ascii_digit_streamer.sv
// Binary-to-ASCII decimal streamer: sequential double-dabble, then MSD-first characters with
// leading-zero suppression. Define ASCII_DIGIT_NEWLINE_EN to append a trailing 8'h0A.
module ascii_digit_streamer #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NDIG  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_value,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic             busy
);

   localparam int unsigned BcdW = 4 * NDIG;
   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [7:0] DigitTab [10] = '{"0", "1", "2", "3", "4", "5", "6", "7", "8", "9"};

   function automatic bit digits_ok();
      logic [127:0] p;
      p = 128'd1;
      for (int k = 0; k < int'(NDIG); k++) p = p * 128'd10;
      return p > (128'd1 << WIDTH);
   endfunction

   if (!digits_ok()) begin : g_ndig_check
      $error("NDIG too small: 10**NDIG must exceed 2**WIDTH");
   end

   function automatic logic [7:0] to_ascii(input logic [3:0] d);
      // Digits >= 10 cannot arise from double-dabble; '?' flags a broken datapath.
      if (d < 4'd10) return DigitTab[d];
      return 8'h3F;
   endfunction

   function automatic logic [3:0] nibble(input logic [BcdW-1:0] b, input logic [IdxW-1:0] i);
      logic [3:0] r;
      r = '0;
      for (int k = 0; k < int'(NDIG); k++) begin
         if (i == IdxW'(k)) r = b[4*k +: 4];
      end
      return r;
   endfunction

   function automatic logic [IdxW-1:0] msd(input logic [BcdW-1:0] b);
      logic [IdxW-1:0] m;
      m = '0;
      for (int k = 0; k < int'(NDIG); k++) begin
         if (b[4*k +: 4] != 4'd0) m = IdxW'(k);
      end
      return m;
   endfunction

   typedef enum logic [1:0] {
      StIdle,
      StConv,
      StEmit
`ifdef ASCII_DIGIT_NEWLINE_EN
      , StNl
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d, sreg_step;
   logic [BcdW-1:0]  bcd_q, bcd_d, bcd_adj, bcd_step;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [IdxW-1:0]  idx_q, idx_d, msd_step;
   logic [7:0]       data_q, data_d;
   logic             last_q, last_d;

   // One double-dabble step: per-nibble +3 correction (no inter-nibble carry), then shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < int'(NDIG); k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
      bcd_step  = {bcd_adj[BcdW-2:0], sreg_q[WIDTH-1]};
      sreg_step = sreg_q << 1;
      msd_step  = msd(bcd_step);
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sreg_d  = in_value;
               bcd_d   = '0;
               cnt_d   = CntW'(WIDTH);
               state_d = StConv;
            end
         end
         StConv: begin
            sreg_d = sreg_step;
            bcd_d  = bcd_step;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
               state_d = StEmit;
               idx_d   = msd_step;
               data_d  = to_ascii(nibble(bcd_step, msd_step));
`ifdef ASCII_DIGIT_NEWLINE_EN
               last_d  = 1'b0;
`else
               last_d  = (msd_step == '0);
`endif
            end
         end
         StEmit: begin
            if (out_ready) begin
               if (idx_q == '0) begin
`ifdef ASCII_DIGIT_NEWLINE_EN
                  state_d = StNl;
                  data_d  = 8'h0A;
                  last_d  = 1'b1;
`else
                  state_d = StIdle;
                  data_d  = 8'h00;
                  last_d  = 1'b0;
`endif
               end else begin
                  idx_d  = idx_q - 1'b1;
                  data_d = to_ascii(nibble(bcd_q, idx_q - 1'b1));
`ifdef ASCII_DIGIT_NEWLINE_EN
                  last_d = 1'b0;
`else
                  last_d = (idx_q == IdxW'(1));
`endif
               end
            end
         end
`ifdef ASCII_DIGIT_NEWLINE_EN
         StNl: begin
            if (out_ready) begin
               state_d = StIdle;
               data_d  = 8'h00;
               last_d  = 1'b0;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sreg_q  <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= 8'h00;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      in_ready  = (state_q == StIdle);
      busy      = (state_q != StIdle);
`ifdef ASCII_DIGIT_NEWLINE_EN
      out_valid = (state_q == StEmit) || (state_q == StNl);
`else
      out_valid = (state_q == StEmit);
`endif
      out_data  = data_q;
      out_last  = last_q;
   end

endmodule

// File: tb/tb_ascii_digit_streamer.sv
// Self-checking bench for ascii_digit_streamer: decimal-string reference model, directed
// cases, backpressure, mid-stream reset, back-to-back and randomized values.
module tb_ascii_digit_streamer;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NDIG  = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_value = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [7:0]       out_data;
   logic             out_last;
   logic             busy;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] exp_q[$];

   ascii_digit_streamer #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_value  (in_value),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Expected character stream: plain decimal rendering of the value.
   function automatic void model(input int unsigned v);
      int unsigned x;
      exp_q.delete();
      x = v;
      if (x == 0) exp_q.push_back(8'h30);
      while (x > 0) begin
         exp_q.push_front(8'(8'h30 + (x % 10)));
         x = x / 10;
      end
`ifdef ASCII_DIGIT_NEWLINE_EN
      exp_q.push_back(8'h0A);
`endif
   endfunction

   // mode 0: ready high; 1: ready toggles each valid cycle; 2: random ready.
   task automatic run_value(input logic [WIDTH-1:0] v, input int mode, input bit hold,
                            input logic [WIDTH-1:0] next_v);
      int t, got, first_t, waitc, k;
      bit stalled, r, tog, el;
      logic [7:0] prev_data;
      model(int'(v));
      k = exp_q.size();
      waitc = 0;
      while (!in_ready && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
      else n_pass++;
      in_valid  = 1'b1;
      in_value  = v;
      out_ready = 1'b0;
      @(negedge clk);
      t = 1;
      in_valid = hold;
      in_value = hold ? next_v : WIDTH'($urandom);
      got = 0; first_t = -1; stalled = 0; tog = 0; prev_data = 8'h00;
      while (got < k && t < 200) begin
         if (stalled) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data)
               $display("FAIL stall_hold v=%0d: valid=%b data=%h required valid=1 data=%h",
                        v, out_valid, out_data, prev_data);
            else n_pass++;
         end
         if (out_valid === 1'b1) begin
            if (first_t < 0) first_t = t;
            el = (got == k - 1);
            n_checks++;
            if (out_data !== exp_q[got] || out_last !== el)
               $display("FAIL char v=%0d #%0d: data=%h last=%b required data=%h last=%b",
                        v, got, out_data, out_last, exp_q[got], el);
            else n_pass++;
            case (mode)
               0: r = 1'b1;
               1: begin r = tog; tog = ~tog; end
               default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            stalled   = !r;
            prev_data = out_data;
            if (r) got++;
         end else begin
            out_ready = 1'($urandom_range(0, 1));
            stalled   = 1'b0;
         end
         @(negedge clk);
         t++;
      end
      out_ready = 1'b0;
      n_checks++;
      if (got != k) $display("FAIL char_count v=%0d: got %0d required %0d", v, got, k);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL idle_after v=%0d: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                  v, in_ready, out_valid, busy);
      else n_pass++;
      if (mode == 0) begin
         n_checks++;
         if (first_t != int'(WIDTH) + 1 || t != int'(WIDTH) + k + 1)
            $display("FAIL latency v=%0d: first=%0d ready_back=%0d required %0d %0d",
                     v, first_t, t, WIDTH + 1, int'(WIDTH) + k + 1);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0
          || busy !== 1'b0)
         $display("FAIL reset: rdy=%b vld=%b data=%h last=%b busy=%b required 1 0 00 0 0",
                  in_ready, out_valid, out_data, out_last, busy);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      run_value(16'd1, 0, 1'b0, '0);
      run_value(16'd0, 0, 1'b0, '0);
      run_value(16'd65535, 0, 1'b0, '0);
      run_value(16'd1000, 0, 1'b0, '0);
   endtask

   task automatic test_backpressure();
      run_value(16'd42, 1, 1'b0, '0);
   endtask

   task automatic test_reset_abort();
      int waitc;
      in_valid = 1'b1;
      in_value = 16'd12345;
      @(negedge clk);
      in_valid = 1'b0;
      waitc = 0;
      while (out_valid !== 1'b1 && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h31)
         $display("FAIL abort_first: valid=%b data=%h required 1 31", out_valid, out_data);
      else n_pass++;
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0
          || busy !== 1'b0)
         $display("FAIL abort_reset: rdy=%b vld=%b data=%h last=%b busy=%b required 1 0 00 0 0",
                  in_ready, out_valid, out_data, out_last, busy);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) $display("FAIL abort_quiet: out_valid=%b required 0", out_valid);
         else n_pass++;
      end
      out_ready = 1'b0;
      run_value(16'd7, 0, 1'b0, '0);
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] a, b, c;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom_range(0, 99));
      c = WIDTH'($urandom);
      run_value(a, 0, 1'b1, b);
      run_value(b, 0, 1'b1, c);
      run_value(c, 0, 1'b0, '0);
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] v;
      for (int i = 0; i < 30; i++) begin
         v = WIDTH'($urandom) >> $urandom_range(0, 15);
         run_value(v, int'($urandom_range(0, 2)), 1'b0, '0);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
